// File: rtl/fifo_wr_rr_arbiter_if.sv
// Write-port sharing bus: requester streams toward the arbiter,
// FIFO write pins and grant status away from it.
interface fifo_wr_rr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_full;
   logic                          fifo_w_en;
   logic [DATA_WIDTH-1:0]         fifo_data_in;
   logic                          grant_valid;
   logic [ID_W-1:0]               grant_id;

   modport master (
      input  req_valid, req_data, fifo_full,
      output req_ready, fifo_w_en, fifo_data_in,
      output grant_valid, grant_id
   );

   modport slave (
      output req_valid, req_data, fifo_full,
      input  req_ready, fifo_w_en, fifo_data_in,
      input  grant_valid, grant_id
   );
endinterface

// File: rtl/fifo_wr_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ
// valid/ready requesters, with bounded bursts and full-flag stalls.
module fifo_wr_rr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fifo_wr_rr_arbiter_if.master bus
);
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam int SW    = ID_W + 1;
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

   state_e                state_q, state_d;
   logic [ID_W-1:0]       owner_q, owner_d;
   logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
   logic [ID_W-1:0]       start, pick;
   logic [NUM_REQ-1:0]    mask, rot, ready;
   logic [2*NUM_REQ-1:0]  dbl;
   logic [SW-1:0]         sum;
   logic [DATA_WIDTH-1:0] data;
   logic                  in_grant, own_valid, xfer;
   logic                  last_beat, rel, found;

   function automatic logic [ID_W-1:0] wrap_inc(
      input logic [ID_W-1:0] x
   );
      return (x == LAST_ID) ? '0 : x + 1'b1;
   endfunction

   always_comb begin
      own_valid = 1'b0;
      data      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == ID_W'(i)) begin
            own_valid = bus.req_valid[i];
            data      = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      in_grant = (state_q == GRANT);
      ready    = '0;
      if (in_grant && !bus.fifo_full) ready[owner_q] = 1'b1;
      xfer      = in_grant && own_valid && !bus.fifo_full;
      last_beat = xfer && (beat_cnt_q == CNT_W'(MAX_BURST - 1));
      rel       = in_grant && (last_beat || !own_valid);
      start     = in_grant ? wrap_inc(owner_q) : wrap_inc(rr_ptr_q);
      // an exhausted owner may be re-picked, but only as the last choice
      mask = bus.req_valid;
      if (in_grant && !last_beat) mask[owner_q] = 1'b0;
   end

   always_comb begin
      dbl   = {mask, mask} >> start;
      rot   = dbl[NUM_REQ-1:0];
      found = |rot;
      sum   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) sum = {1'b0, start} + SW'(k);
      end
      if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
      pick = sum[ID_W-1:0];
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      beat_cnt_d = beat_cnt_q;
      rr_ptr_d   = rr_ptr_q;
      if (!in_grant) begin
         if (found) begin
            state_d    = GRANT;
            owner_d    = pick;
            beat_cnt_d = '0;
         end
      end else if (rel) begin
         rr_ptr_d   = owner_q;
         beat_cnt_d = '0;
         if (found) owner_d = pick;
         else       state_d = IDLE;
      end else if (xfer) begin
         beat_cnt_d = beat_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         beat_cnt_q <= '0;
         rr_ptr_q   <= LAST_ID;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         beat_cnt_q <= beat_cnt_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   assign bus.req_ready    = ready;
   assign bus.fifo_w_en    = xfer;
   assign bus.fifo_data_in = in_grant ? data : '0;
   assign bus.grant_valid  = in_grant;
   assign bus.grant_id     = in_grant ? owner_q : '0;
endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// Scoreboard bench for fifo_wr_rr_arbiter: a queue-based rotation
// model predicts every cycle; a negedge monitor compares.
module tb_fifo_wr_rr_arbiter;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 4;

   typedef struct packed {
      logic          gv;
      logic [1:0]    gid;
      logic [N-1:0]  rdy;
      logic          we;
      logic [DW-1:0] d;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   exp_t          exp_q[$];
   logic [DW-1:0] tb_fifo[$];
   logic [DW-1:0] m_wr[$];
   logic [DW-1:0] dat[N];

   bit m_busy;
   int m_owner, m_beats, m_last;

   fifo_wr_rr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

   fifo_wr_rr_arbiter #(
      .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
      end
   endtask

   // first valid index after 'from' going round; 'from' itself is last
   function automatic int find_next(input int from, input logic [N-1:0] v,
                                    input bit excl_from);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (from + k) % N;
         if (v[c] && !(excl_from && c == from)) return c;
      end
      return -1;
   endfunction

   task automatic model_cycle(input logic [N-1:0] v, input bit full);
      exp_t e;
      int   nxt;
      e = '0;
      if (m_busy) begin
         e.gv  = 1'b1;
         e.gid = 2'(m_owner);
         e.rdy = full ? '0 : N'(1 << m_owner);
         e.d   = dat[m_owner];
         if (v[m_owner] && !full) begin
            e.we = 1'b1;
            m_wr.push_back(dat[m_owner]);
            dat[m_owner] = dat[m_owner] + 8'd1;
            m_beats++;
         end
         if (m_beats == MB || !v[m_owner]) begin
            nxt = find_next(m_owner, v, m_beats != MB);
            m_last = m_owner;
            if (nxt >= 0) begin
               m_owner = nxt;
               m_beats = 0;
            end else begin
               m_busy = 1'b0;
            end
         end
      end else begin
         nxt = find_next(m_last, v, 1'b0);
         if (nxt >= 0) begin
            m_busy  = 1'b1;
            m_owner = nxt;
            m_beats = 0;
         end
      end
      exp_q.push_back(e);
   endtask

   // fm: 0 = not full, 1 = full, 2 = full from the bench FIFO (depth 8)
   task automatic apply(input logic [N-1:0] v, input int fm);
      bit full;
      full = (fm == 2) ? (tb_fifo.size() >= 8) : (fm == 1);
      bus.req_valid = v;
      bus.fifo_full = full;
      for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = dat[i];
      model_cycle(v, full);
   endtask

   task automatic step(input logic [N-1:0] v, input int fm);
      @(posedge clk);
      #1;
      apply(v, fm);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      bus.req_valid = '1;
      bus.fifo_full = 1'b0;
      #1;
      chk("rst_ready", 32'(bus.req_ready), 0);
      chk("rst_wen", 32'(bus.fifo_w_en), 0);
      chk("rst_gv", 32'(bus.grant_valid), 0);
      chk("rst_data", 32'(bus.fifo_data_in), 0);
      m_busy  = 1'b0;
      m_owner = 0;
      m_beats = 0;
      m_last  = N - 1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      apply('1, 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("grant", 32'({bus.grant_valid, bus.grant_id}),
                32'({e.gv, e.gid}));
            chk("ready", 32'(bus.req_ready), 32'(e.rdy));
            chk("w_en", 32'(bus.fifo_w_en), 32'(e.we));
            chk("data", 32'(bus.fifo_data_in), 32'(e.d));
            chk("ready_onehot0", 32'($onehot0(bus.req_ready)), 1);
            chk("wen_while_full", 32'(bus.fifo_w_en & bus.fifo_full), 0);
         end
         if (rst_n && bus.fifo_w_en) tb_fifo.push_back(bus.fifo_data_in);
      end
   end

   initial begin : stim
      logic [N-1:0] v;
      bus.req_valid = '1;
      bus.req_data  = '0;
      bus.fifo_full = 1'b0;
      for (int i = 0; i < N; i++) dat[i] = 8'(i * 64);
      #12;
      do_reset();
      // round robin with all requesters valid
      repeat (22) step('1, 0);
      // backpressure mid-burst
      repeat (3) step('1, 1);
      repeat (8) step('1, 0);
      // early release of req 2 handing over to req 3
      repeat (2) step('0, 0);
      repeat (3) step(4'b0100, 0);
      repeat (6) step(4'b1000, 0);
      // lone requester
      repeat (2) step('0, 0);
      repeat (12) step(4'b0001, 0);
      // randomized streams and full flag
      v = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 99) < 25) v[i] = ~v[i];
         step(v, ($urandom_range(0, 99) < 20) ? 1 : 0);
      end
      // reset in the middle of a burst
      repeat (2) step('1, 0);
      do_reset();
      repeat (10) step('1, 0);
      // fill an 8-deep FIFO from all requesters
      repeat (3) step('0, 0);
      tb_fifo.delete();
      m_wr.delete();
      repeat (20) step('1, 2);
      repeat (2) step('0, 2);
      @(negedge clk);
      #1;
      chk("fifo_count", tb_fifo.size(), 8);
      for (int i = 0; i < tb_fifo.size() && i < m_wr.size(); i++)
         chk("fifo_order", 32'(tb_fifo[i]), 32'(m_wr[i]));
      chk("exp_drain", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
